// File: rtl/axis_converter_pkg_prm.sv
// Shared constants and FSM state types for the AXI-Lite to AXI-Stream bridge.
package axis_converter_pkg_prm;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Per-channel register offsets (channel c sits at c*0x10)
  localparam logic [3:0] REG_TX_DATA = 4'h0;
  localparam logic [3:0] REG_TX_LAST = 4'h4;
  localparam logic [3:0] REG_RX_DATA = 4'h8;
  localparam logic [3:0] REG_STATUS  = 4'hC;

  // Global interrupt registers (only decoded when the irq feature is built in)
  localparam logic [7:0] REG_IRQ_MASK = 8'hF0;
  localparam logic [7:0] REG_IRQ_STAT = 8'hF4;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  // Packs the STATUS register layout in one place.
  function automatic logic [31:0] status_word(input logic [7:0] tx_lvl,
                                              input logic [7:0] rx_lvl,
                                              input logic       rx_last,
                                              input logic       tx_full,
                                              input logic       rx_empty);
    return {13'd0, rx_empty, tx_full, rx_last, rx_lvl, tx_lvl};
  endfunction

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bundle with parametrised address/data widths.
interface axil_if #(
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                        awvalid;
  logic                        awready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic                        arvalid;
  logic                        arready;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport s_axil (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m_axil (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axis_fifo_sync.sv
// Single-clock first-word-fall-through FIFO with occupancy level.
// push is ignored when full, pop is ignored when empty; both in one cycle keep level.
module axis_fifo_sync #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/axil_axis_bridge.sv
// AXI4-Lite slave bridging register accesses to CH_NUM AXI-Stream TX/RX channel pairs.
// Optional feature macro: AXIL_BRIDGE_IRQ_EN adds IRQ_MASK/IRQ_STAT registers and the irq output.
// Handshake rule on every channel (AXI-Lite and stream): a beat transfers on a rising
// edge where valid and ready are both high; valid never waits on ready.
module axil_axis_bridge
  import axis_converter_pkg_prm::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int CH_NUM         = 2,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                               aclk,
  input  logic                               areset,
  axil_if.s_axil                             s_axil,
  output logic [CH_NUM*AXI_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [CH_NUM-1:0]                  m_axis_tlast,
  output logic [CH_NUM-1:0]                  m_axis_tvalid,
  input  logic [CH_NUM-1:0]                  m_axis_tready,
  input  logic [CH_NUM*AXI_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [CH_NUM-1:0]                  s_axis_tlast,
  input  logic [CH_NUM-1:0]                  s_axis_tvalid,
  output logic [CH_NUM-1:0]                  s_axis_tready,
`ifdef AXIL_BRIDGE_IRQ_EN
  output logic                               irq,
`endif
  output w_state_t                           dbg_wstate,
  output r_state_t                           dbg_rstate
);
  localparam int DW   = AXI_DATA_WIDTH;
  localparam int AW   = AXI_ADDR_WIDTH;
  localparam int SW   = DW / 8;
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  // ---------------- channel FIFOs ----------------
  logic [CH_NUM-1:0] tx_push, tx_pop, tx_full, tx_empty;
  logic [CH_NUM-1:0] rx_push, rx_pop, rx_full, rx_empty;
  logic [DW:0]       tx_head  [CH_NUM];
  logic [DW:0]       rx_head  [CH_NUM];
  logic [LW-1:0]     tx_level [CH_NUM];
  logic [LW-1:0]     rx_level [CH_NUM];
  logic [DW:0]       tx_wdata;

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    axis_fifo_sync #(.WIDTH(DW+1), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(aclk), .rst(areset), .push(tx_push[c]), .push_data(tx_wdata),
      .pop(tx_pop[c]), .head(tx_head[c]), .full(tx_full[c]),
      .empty(tx_empty[c]), .level(tx_level[c])
    );
    axis_fifo_sync #(.WIDTH(DW+1), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(aclk), .rst(areset), .push(rx_push[c]),
      .push_data({s_axis_tlast[c], s_axis_tdata[c*DW +: DW]}),
      .pop(rx_pop[c]), .head(rx_head[c]), .full(rx_full[c]),
      .empty(rx_empty[c]), .level(rx_level[c])
    );
    assign m_axis_tvalid[c]          = ~tx_empty[c] & ~areset;
    assign m_axis_tdata[c*DW +: DW]  = tx_head[c][DW-1:0];
    assign m_axis_tlast[c]           = tx_head[c][DW];
    assign tx_pop[c]                 = m_axis_tvalid[c] & m_axis_tready[c];
    assign s_axis_tready[c]          = ~rx_full[c] & ~areset;
    assign rx_push[c]                = s_axis_tvalid[c] & s_axis_tready[c];
  end

`ifdef AXIL_BRIDGE_IRQ_EN
  logic [CH_NUM-1:0] irq_mask;
  logic              irq_q;
  logic              w_mask_we;
`endif

  // ---------------- write channel ----------------
  w_state_t        wstate, wstate_nx;
  logic            aw_held, w_held;
  logic [AW-1:0]   awaddr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic            awready_c, wready_c, bvalid_c;
  logic            aw_hs, w_hs, w_fire;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [SW-1:0]   w_strb;
  logic [1:0]      w_resp, bresp_q;
  logic            w_push_en, w_push_last;
  logic [CH_W-1:0] w_ch;

  // Address and data are merged from the held copy or the live bus, whichever arrives.
  assign aw_hs    = s_axil.awvalid & awready_c;
  assign w_hs     = s_axil.wvalid & wready_c;
  assign w_addr   = aw_held ? awaddr_q : s_axil.awaddr;
  assign w_data   = w_held ? wdata_q : s_axil.wdata;
  assign w_strb   = w_held ? wstrb_q : s_axil.wstrb;
  assign w_fire   = (wstate == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
  assign tx_wdata = {w_push_last, w_data};

  // Write decode: response code and whether a TX push is allowed.
  always_comb begin
    w_resp      = RESP_DECERR;
    w_push_en   = 1'b0;
    w_push_last = 1'b0;
    w_ch        = w_addr[4 +: CH_W];
`ifdef AXIL_BRIDGE_IRQ_EN
    w_mask_we   = 1'b0;
`endif
    if (int'(w_addr[AW-1:4]) < CH_NUM) begin
      case ({w_addr[3:2], 2'b00})
        REG_TX_DATA, REG_TX_LAST: begin
          if ((&w_strb) && !tx_full[w_ch]) begin
            w_resp      = RESP_OKAY;
            w_push_en   = 1'b1;
            w_push_last = (w_addr[3:2] == REG_TX_LAST[3:2]);
          end else begin
            w_resp = RESP_SLVERR;
          end
        end
        default: w_resp = RESP_SLVERR;
      endcase
    end
`ifdef AXIL_BRIDGE_IRQ_EN
    else if ({w_addr[AW-1:2], 2'b00} == AW'(REG_IRQ_MASK)) begin
      w_resp    = RESP_OKAY;
      w_mask_we = 1'b1;
    end else if ({w_addr[AW-1:2], 2'b00} == AW'(REG_IRQ_STAT)) begin
      w_resp = RESP_SLVERR;
    end
`endif
  end

  // Write FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) wstate <= W_IDLE;
    else        wstate <= wstate_nx;
  end

  // Write FSM next state.
  always_comb begin
    wstate_nx = wstate;
    case (wstate)
      W_IDLE:  if (w_fire) wstate_nx = W_RESP;
      W_RESP:  if (s_axil.bready) wstate_nx = W_IDLE;
      default: wstate_nx = W_IDLE;
    endcase
  end

  // Write FSM outputs: independent AW/W readies, B valid and the TX push strobe.
  always_comb begin
    awready_c = ~areset & (wstate == W_IDLE) & ~aw_held;
    wready_c  = ~areset & (wstate == W_IDLE) & ~w_held;
    bvalid_c  = (wstate == W_RESP);
    for (int c = 0; c < CH_NUM; c++) begin
      tx_push[c] = w_fire & w_push_en & (w_ch == CH_W'(c));
    end
  end

  // Write datapath: hold AW/W until both are present, register the response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else if (w_fire) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bresp_q  <= w_resp;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axil.awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axil.wdata;
        wstrb_q <= s_axil.wstrb;
      end
    end
  end

  assign s_axil.awready = awready_c;
  assign s_axil.wready  = wready_c;
  assign s_axil.bvalid  = bvalid_c;
  assign s_axil.bresp   = bresp_q;
  assign dbg_wstate     = wstate;

  // ---------------- read channel ----------------
  r_state_t        rstate, rstate_nx;
  logic            arready_c, rvalid_c, r_fire;
  logic [1:0]      r_resp, rresp_q;
  logic [DW-1:0]   r_data, rdata_q;
  logic            r_pop_en;
  logic [CH_W-1:0] r_ch;

  assign r_fire = s_axil.arvalid & arready_c;

  // Read decode on the live address; STATUS samples levels in the accept cycle.
  always_comb begin
    r_resp   = RESP_DECERR;
    r_data   = '0;
    r_pop_en = 1'b0;
    r_ch     = s_axil.araddr[4 +: CH_W];
    if (int'(s_axil.araddr[AW-1:4]) < CH_NUM) begin
      case ({s_axil.araddr[3:2], 2'b00})
        REG_RX_DATA: begin
          if (!rx_empty[r_ch]) begin
            r_resp   = RESP_OKAY;
            r_data   = rx_head[r_ch][DW-1:0];
            r_pop_en = 1'b1;
          end else begin
            r_resp = RESP_SLVERR;
          end
        end
        REG_STATUS: begin
          r_resp = RESP_OKAY;
          r_data = DW'(status_word(8'(tx_level[r_ch]), 8'(rx_level[r_ch]),
                                   rx_head[r_ch][DW] & ~rx_empty[r_ch],
                                   tx_full[r_ch], rx_empty[r_ch]));
        end
        default: r_resp = RESP_SLVERR;
      endcase
    end
`ifdef AXIL_BRIDGE_IRQ_EN
    else if ({s_axil.araddr[AW-1:2], 2'b00} == AW'(REG_IRQ_MASK)) begin
      r_resp = RESP_OKAY;
      r_data = DW'(irq_mask);
    end else if ({s_axil.araddr[AW-1:2], 2'b00} == AW'(REG_IRQ_STAT)) begin
      r_resp = RESP_OKAY;
      r_data = DW'(~rx_empty);
    end
`endif
  end

  // Read FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) rstate <= R_IDLE;
    else        rstate <= rstate_nx;
  end

  // Read FSM next state.
  always_comb begin
    rstate_nx = rstate;
    case (rstate)
      R_IDLE:  if (r_fire) rstate_nx = R_RESP;
      R_RESP:  if (s_axil.rready) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  // Read FSM outputs: AR ready, R valid and the RX pop strobe.
  always_comb begin
    arready_c = ~areset & (rstate == R_IDLE);
    rvalid_c  = (rstate == R_RESP);
    for (int c = 0; c < CH_NUM; c++) begin
      rx_pop[c] = r_fire & r_pop_en & (r_ch == CH_W'(c));
    end
  end

  // Read datapath: capture data/response at AR accept.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (r_fire) begin
      rdata_q <= r_data;
      rresp_q <= r_resp;
    end
  end

  assign s_axil.arready = arready_c;
  assign s_axil.rvalid  = rvalid_c;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign dbg_rstate     = rstate;

`ifdef AXIL_BRIDGE_IRQ_EN
  // Interrupt mask register and registered irq: any enabled channel with RX data pending.
  always_ff @(posedge aclk) begin
    if (areset) begin
      irq_mask <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (w_fire && w_mask_we) irq_mask <= w_data[CH_NUM-1:0];
      irq_q <= |(irq_mask & ~rx_empty);
    end
  end
  assign irq = irq_q;
`endif

  // Byte-offset bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_addr[1:0], s_axil.araddr[1:0]};
endmodule

// File: doc/axil_axis_bridge.md
# axil_axis_bridge

AXI4-Lite slave that bridges CPU register accesses to multiple AXI-Stream channels. Each channel has a TX FIFO, filled by register writes and drained onto a master stream, and an RX FIFO, filled from a slave stream and drained by register reads. It sits between the processor's AXI-Lite interconnect (`axil_if.s_axil`) and the stream datapath, generalising the single-channel lite converter in width, depth and channel count.

## Interface
- AXI_DATA_WIDTH, 32 — AXI-Lite and stream data width; 32 or 64.
- AXI_ADDR_WIDTH, 8 — AXI-Lite address width; must cover CH_NUM*16 bytes.
- CH_NUM, 2 — number of stream channels, 1..8.
- FIFO_DEPTH, 16 — entries per TX and per RX FIFO; power of two, ≥2.
- aclk  in  1  — single clock for all logic.
- areset  in  1  — synchronous, active-high reset.
- s_axil  modport  axil_if.s_axil  — AXI-Lite slave port.
- m_axis_tdata  out  CH_NUM*AXI_DATA_WIDTH  — TX stream data, channel c at slice c.
- m_axis_tlast  out  CH_NUM  — TX end of packet.
- m_axis_tvalid  out  CH_NUM  — TX valid.
- m_axis_tready  in  CH_NUM  — TX ready.
- s_axis_tdata  in  CH_NUM*AXI_DATA_WIDTH  — RX stream data.
- s_axis_tlast  in  CH_NUM  — RX end of packet.
- s_axis_tvalid  in  CH_NUM  — RX valid.
- s_axis_tready  out  CH_NUM  — RX ready; equals RX FIFO not full.
- irq  out  1  — only present with AXIL_BRIDGE_IRQ_EN.

## Operation
- Register map per channel c, base c*0x10:
  - +0x0 TX_DATA (W): push {tlast=0, wdata}.
  - +0x4 TX_LAST (W): push {tlast=1, wdata}.
  - +0x8 RX_DATA (R): pop the RX head and return its data.
  - +0xC STATUS (R): [7:0] TX level, [15:8] RX level, [16] RX head tlast, [17] TX full, [18] RX empty.
- Write FSM states:
  - W_IDLE: awready=1 and wready=1, each latched independently. Address and data may arrive in either order or in the same cycle.
  - Once both are held, go to W_RESP, performing the push in the transition cycle.
  - W_RESP: bvalid=1 until bready, then return to W_IDLE.
- Read FSM states:
  - R_IDLE: arready=1. On arvalid, decode and capture rdata/rresp, performing the pop in the same cycle, then go to R_RESP.
  - R_RESP: rvalid=1 until rready, then return to R_IDLE.
- Responses:
  - OKAY=2'b00 on success.
  - SLVERR=2'b10 in each of these cases; the access has no side effect:
    - write to a full TX FIFO;
    - wstrb not all-ones on a data write;
    - read of RX_DATA with the RX FIFO empty (rdata=0);
    - write to RX_DATA or STATUS;
    - read of TX_DATA or TX_LAST.
  - DECERR=2'b11 for channel index ≥ CH_NUM, with rdata=0.
- Addresses are word aligned; awaddr[1:0] and araddr[1:0] are ignored.
- The write and read FSMs run concurrently. Same-cycle push/pop on one FIFO is legal, and the level is unchanged.
- STATUS reads return levels sampled in the R_IDLE accept cycle.
- Stream side: m_axis_tvalid = TX FIFO not empty, with tdata/tlast taken from the head. Each FIFO is 33/65 bits wide (data+last).

## Timing
- Reset values:
  - awready, wready, arready = 0 in the reset cycle, 1 afterwards.
  - bvalid, rvalid = 0; bresp, rresp = 0; rdata = 0.
  - m_axis_tvalid = 0; s_axis_tready = 0 during reset.
  - All FIFOs empty; irq = 0.
- Write latency: bvalid rises the cycle after the later of the AW and W handshakes. A pushed word is visible on m_axis_tvalid one cycle after the push.
- Read latency: rvalid rises the cycle after the AR handshake.
- Peak throughput: one write per 2 cycles, one read per 2 cycles.
- TX FIFO full + push + same-cycle m_axis pop: the push is still rejected (full is sampled before the pop).
- RX FIFO full: s_axis_tready=0. Simultaneous RX_DATA pop frees a slot for the next cycle, not the current one.
- Reset mid-transaction: outstanding responses are discarded and FIFO contents are lost.

## Configuration
- AXIL_BRIDGE_IRQ_EN defined:
  - Adds register 0xF0 IRQ_MASK (RW, bit c = RX-not-empty enable for channel c) and 0xF4 IRQ_STAT (R, raw RX-not-empty per channel).
  - irq = |(mask & ~rx_empty), registered, so it asserts one cycle after the condition.
  - IRQ_MASK resets to 0.
- Undefined: no irq port, no IRQ registers; 0xF0/0xF4 decode as DECERR.

## Structure
- New package axis_converter_pkg_prm holds:
  - response constants RESP_OKAY, RESP_SLVERR, RESP_DECERR;
  - register offsets REG_TX_DATA, REG_TX_LAST, REG_RX_DATA, REG_STATUS, REG_IRQ_MASK, REG_IRQ_STAT;
  - the write and read FSM state enums.
- axil_if is used with the parametrised widths.
- One sub-module, axis_fifo_sync (WIDTH, DEPTH: level output, full/empty flags, first-word-fall-through), instantiated 2*CH_NUM times.

## Test plan
- Write 0xA5A5_0001 to 0x00, then 0x0000_0002 to 0x04, with m_axis_tready[0]=1 → channel 0 emits 0xA5A5_0001 (tlast=0) then 0x0000_0002 (tlast=1). Both bresp=OKAY.
- Drive s_axis ch1 with 0x11, 0x22 (tlast on 0x22), then read 0x1C → STATUS RX level=2, bit16=0. Read 0x18 twice → 0x11 then 0x22, OKAY. A third read → SLVERR, rdata=0.
- Hold m_axis_tready[0]=0 and perform 17 writes to 0x00 with FIFO_DEPTH=16 → first 16 OKAY, 17th SLVERR. STATUS TX level=16, bit17=1.
- Present W two cycles before AW, then AW and W in the same cycle → bvalid exactly one cycle after the later handshake, with one push each time.
- Read 0x20 with CH_NUM=2 → rresp=DECERR, rdata=0. Write with wstrb=4'b0011 to 0x00 → SLVERR, TX level unchanged.
- With AXIL_BRIDGE_IRQ_EN: write IRQ_MASK=0x2, push one RX word on ch1 → irq=1 one cycle after s_axis handshake. Read 0x18 → irq=0 the cycle after the pop.
